// File: rtl/comparator_pkg.sv
// Shared flag indices and the packed result type for the comparator block.
package comparator_pkg;

    localparam int FLAG_GT = 0;
    localparam int FLAG_EQ = 1;
    localparam int FLAG_LT = 2;
    localparam int FLAG_GE = 3;
    localparam int FLAG_NE = 4;
    localparam int FLAG_LE = 5;
    localparam int FLAG_W  = 6;

    typedef logic [FLAG_W-1:0] flags_t;

endpackage

// File: rtl/comparator_core.sv
// Combinational N-bit magnitude compare producing all six relational flags.
// Signed mode flips the sign bit so one unsigned N+1-bit subtract serves both modes.
module comparator_core
    import comparator_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         is_signed,
    output flags_t       flags
);

    logic [N-1:0] sign_mask_s;
    logic [N-1:0] a_key_s;
    logic [N-1:0] b_key_s;
    logic [N:0]   diff_s;
    logic         lt_s;
    logic         eq_s;
    logic         gt_s;

    // Order-preserving key mapping, borrow-based compare and flag packing.
    always_comb begin
        sign_mask_s        = {N{1'b0}};
        sign_mask_s[N-1]   = is_signed;
        a_key_s            = a ^ sign_mask_s;
        b_key_s            = b ^ sign_mask_s;
        diff_s             = {1'b0, a_key_s} - {1'b0, b_key_s};
        lt_s               = diff_s[N];
        eq_s               = (diff_s[N-1:0] == {N{1'b0}});
        gt_s               = ~lt_s & ~eq_s;

        flags              = {FLAG_W{1'b0}};
        flags[FLAG_GT]     = gt_s;
        flags[FLAG_EQ]     = eq_s;
        flags[FLAG_LT]     = lt_s;
        flags[FLAG_GE]     = gt_s | eq_s;
        flags[FLAG_NE]     = ~eq_s;
        flags[FLAG_LE]     = lt_s | eq_s;
    end

endmodule

// File: rtl/comparator.sv
// Registered magnitude comparator: one-cycle latency, flags hold while i_valid is low.
// Optional min/max outputs are enabled by defining COMPARATOR_MINMAX_EN.
module comparator
    import comparator_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         i_clock,
    input  logic         i_reset,
    input  logic         i_valid,
    input  logic         i_signed,
    input  logic [N-1:0] i_left,
    input  logic [N-1:0] i_right,
    output logic         o_valid,
    output logic         o_greater,
    output logic         o_equal,
    output logic         o_less,
    output logic         o_greater_equal,
    output logic         o_not_equal,
    output logic         o_less_equal
`ifdef COMPARATOR_MINMAX_EN
    ,
    output logic [N-1:0] o_max,
    output logic [N-1:0] o_min
`endif
);

    flags_t core_flags_s;
    flags_t flags_d;
    flags_t flags_q;
    logic   valid_d;
    logic   valid_q;

    comparator_core #(.N(N)) u_core (
        .a         (i_left),
        .b         (i_right),
        .is_signed (i_signed),
        .flags     (core_flags_s)
    );

    // Capture a fresh result on valid; otherwise hold so idle operands never leak in.
    always_comb begin
        valid_d = i_valid;
        if (i_valid) begin
            flags_d = core_flags_s;
        end else begin
            flags_d = flags_q;
        end
    end

    // Result and valid registers.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            valid_q <= 1'b0;
            flags_q <= {FLAG_W{1'b0}};
        end else begin
            valid_q <= valid_d;
            flags_q <= flags_d;
        end
    end

    assign o_valid         = valid_q;
    assign o_greater       = flags_q[FLAG_GT];
    assign o_equal         = flags_q[FLAG_EQ];
    assign o_less          = flags_q[FLAG_LT];
    assign o_greater_equal = flags_q[FLAG_GE];
    assign o_not_equal     = flags_q[FLAG_NE];
    assign o_less_equal    = flags_q[FLAG_LE];

`ifdef COMPARATOR_MINMAX_EN
    logic [N-1:0] max_d;
    logic [N-1:0] max_q;
    logic [N-1:0] min_d;
    logic [N-1:0] min_q;

    // Select max/min from the same compare that feeds the flags.
    always_comb begin
        if (!i_valid) begin
            max_d = max_q;
            min_d = min_q;
        end else if (core_flags_s[FLAG_GE]) begin
            max_d = i_left;
            min_d = i_right;
        end else begin
            max_d = i_right;
            min_d = i_left;
        end
    end

    // Min/max registers, updated alongside the flags.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            max_q <= {N{1'b0}};
            min_q <= {N{1'b0}};
        end else begin
            max_q <= max_d;
            min_q <= min_d;
        end
    end

    assign o_max = max_q;
    assign o_min = min_q;
`endif

endmodule

// File: tb/tb_comparator.sv
// Self-checking bench for comparator: directed, exhaustive and random stimulus vs an integer model.
module tb_comparator;

    localparam int N = 4;

    logic         i_clock = 1'b0;
    logic         i_reset;
    logic         i_valid;
    logic         i_signed;
    logic [N-1:0] i_left;
    logic [N-1:0] i_right;
    logic         o_valid;
    logic         o_greater;
    logic         o_equal;
    logic         o_less;
    logic         o_greater_equal;
    logic         o_not_equal;
    logic         o_less_equal;
`ifdef COMPARATOR_MINMAX_EN
    logic [N-1:0] o_max;
    logic [N-1:0] o_min;
`endif

    int errors = 0;
    int checks = 0;

    logic         exp_valid;
    logic [5:0]   exp_flags;
`ifdef COMPARATOR_MINMAX_EN
    logic [N-1:0] exp_max;
    logic [N-1:0] exp_min;
`endif
    logic [5:0]   obs_flags;

    assign obs_flags = {o_less_equal, o_not_equal, o_greater_equal, o_less, o_equal, o_greater};

    comparator #(.N(N)) dut (
        .i_clock         (i_clock),
        .i_reset         (i_reset),
        .i_valid         (i_valid),
        .i_signed        (i_signed),
        .i_left          (i_left),
        .i_right         (i_right),
        .o_valid         (o_valid),
        .o_greater       (o_greater),
        .o_equal         (o_equal),
        .o_less          (o_less),
        .o_greater_equal (o_greater_equal),
        .o_not_equal     (o_not_equal),
        .o_less_equal    (o_less_equal)
`ifdef COMPARATOR_MINMAX_EN
        ,
        .o_max           (o_max),
        .o_min           (o_min)
`endif
    );

    always #5 i_clock = ~i_clock;

    function automatic int to_value(input logic s, input logic [N-1:0] x);
        int v;
        v = int'(x);
        if (s && v >= (1 << (N - 1))) v = v - (1 << N);
        return v;
    endfunction

    // Expected flags packed as {le, ne, ge, lt, eq, gt}.
    function automatic logic [5:0] ref_flags(input logic s, input logic [N-1:0] l, input logic [N-1:0] r);
        int a;
        int b;
        a = to_value(s, l);
        b = to_value(s, r);
        return {a <= b, a != b, a >= b, a < b, a == b, a > b};
    endfunction

    task automatic check_outputs(input string tag);
        checks++;
        assert (o_valid === exp_valid) else begin
            errors++;
            $error("FAIL %s valid observed=%b expected=%b", tag, o_valid, exp_valid);
        end
        checks++;
        assert (obs_flags === exp_flags) else begin
            errors++;
            $error("FAIL %s flags(le,ne,ge,lt,eq,gt) observed=%b expected=%b", tag, obs_flags, exp_flags);
        end
`ifdef COMPARATOR_MINMAX_EN
        checks++;
        assert (o_max === exp_max) else begin
            errors++;
            $error("FAIL %s max observed=%0d expected=%0d", tag, o_max, exp_max);
        end
        checks++;
        assert (o_min === exp_min) else begin
            errors++;
            $error("FAIL %s min observed=%0d expected=%0d", tag, o_min, exp_min);
        end
`endif
    endtask

    task automatic model_reset();
        exp_valid = 1'b0;
        exp_flags = 6'b000000;
`ifdef COMPARATOR_MINMAX_EN
        exp_max = {N{1'b0}};
        exp_min = {N{1'b0}};
`endif
    endtask

    // Drive one sample, clock it, update the model and compare.
    task automatic step(input logic v, input logic s, input logic [N-1:0] l,
                        input logic [N-1:0] r, input string tag);
        i_valid  = v;
        i_signed = s;
        i_left   = l;
        i_right  = r;
        @(posedge i_clock);
        #1;
        exp_valid = v;
        if (v) begin
            exp_flags = ref_flags(s, l, r);
`ifdef COMPARATOR_MINMAX_EN
            if (to_value(s, l) >= to_value(s, r)) begin
                exp_max = l;
                exp_min = r;
            end else begin
                exp_max = r;
                exp_min = l;
            end
`endif
        end
        check_outputs(tag);
    endtask

    initial begin
        logic [N-1:0] xval;
        i_reset  = 1'b1;
        i_valid  = 1'b0;
        i_signed = 1'b0;
        i_left   = {N{1'b0}};
        i_right  = {N{1'b0}};
        model_reset();

        repeat (2) @(posedge i_clock);
        #1;
        check_outputs("reset");
        i_reset = 1'b0;
        step(1'b0, 1'b0, 4'd0, 4'd0, "post_reset_idle");

        step(1'b1, 1'b0, 4'd9, 4'd3, "unsigned_9_3");
        step(1'b0, 1'b0, 4'd0, 4'd0, "hold_after_9_3");
        xval = 'x;
        step(1'b0, 1'b1, xval, xval, "hold_x_operands");

        step(1'b1, 1'b1, 4'b1001, 4'b0011, "signed_m7_3");
        step(1'b1, 1'b0, 4'b1001, 4'b0011, "unsigned_9_3_b");
        step(1'b1, 1'b0, 4'hF, 4'hF, "equal_F_unsigned");
        step(1'b1, 1'b1, 4'hF, 4'hF, "equal_F_signed");
        step(1'b1, 1'b1, 4'b1000, 4'b0111, "signed_min_max");
        step(1'b1, 1'b0, 4'b1000, 4'b0111, "unsigned_8_7");

        for (int m = 0; m < 2; m++) begin
            for (int l = 0; l < 16; l++) begin
                for (int r = 0; r < 16; r++) begin
                    step(1'b1, m[0], l[N-1:0], r[N-1:0], "exhaustive");
                end
            end
        end

        for (int k = 0; k < 200; k++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 N'($urandom), N'($urandom), "random");
        end

        step(1'b1, 1'b0, 4'd2, 4'd5, "pre_midreset");
        i_valid  = 1'b1;
        i_signed = 1'b1;
        i_left   = 4'd7;
        i_right  = 4'd1;
        #3;
        i_reset = 1'b1;
        #1;
        model_reset();
        check_outputs("midreset_immediate");
        @(posedge i_clock);
        #1;
        check_outputs("midreset_held");
        i_reset = 1'b0;
        step(1'b1, 1'b0, 4'd9, 4'd3, "after_midreset");
        step(1'b1, 1'b1, 4'd3, 4'b1100, "after_midreset_signed");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
